block_downscale_engine: RTL and testbench
=========================================

// Module: block_downscale_engine
// PURPOSE
//  Self-sequencing image downscaler for the zoom-out path. On start it walks the full
//  source frame block by block: 2x2 or 4x4 blocks, by averaging or by nearest-neighbour.
//  It reads source pixels from a frame RAM with fixed read latency and writes one
//  result pixel per block to the destination RAM in row-major order.
// PARAMETERS
//  SRC_W   320  source width in pixels; must be a multiple of 4
//  SRC_H   240  source height in pixels; must be a multiple of 4
//  ADDR_W  17   read/write address width
//  DATA_W  8    pixel width
//  RD_LAT  2    source RAM read latency in cycles (>=1)
// PORTS
//  clk      in   1       clock
//  rst      in   1       sync reset, active-high
//  start    in   1       1-cycle pulse; begin a frame; ignored while busy
//  mode     in   2       0=avg2x2 1=avg4x4 2=nearest2x 3=nearest4x; latched on start
//  busy     out  1       high from the cycle after an accepted start until done
//  done     out  1       1-cycle pulse after the final write
//  rd_en    out  1       source read strobe
//  rd_addr  out  ADDR_W  source address
//  rd_data  in   DATA_W  valid RD_LAT cycles after the matching rd_en
//  wr_en    out  1       destination write strobe (1 cycle per block)
//  wr_addr  out  ADDR_W  destination address, 0..(SRC_W/F)*(SRC_H/F)-1
//  wr_data  out  DATA_W  result pixel
// BEHAVIOUR
//  - Reset: busy, done, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0.
//    All counters and the accumulator are cleared. FSM goes to IDLE.
//  - rst mid-frame: the frame is aborted immediately. No further wr_en, no done pulse.
//    Read data still in flight is discarded.
//  - Scale and read count: F=2 for modes 0/2, F=4 for modes 1/3.
//    Reads per block K = F*F for average modes, K=1 for nearest modes.
//  - FSM: IDLE -start-> ISSUE -K reads issued-> DRAIN -last data captured-> WRITE.
//    WRITE goes to ISSUE for the next block, or to FIN after the last block.
//    FIN goes to IDLE and pulses done for 1 cycle.
//  - ISSUE: rd_en is high for K consecutive cycles.
//    Block (bx,by), offset (dx,dy): rd_addr = (by*F+dy)*SRC_W + bx*F+dx.
//    Offsets are row-major within the block: dx fastest. Nearest modes read only (0,0).
//  - Data capture: uses a RD_LAT-deep valid shift register fed by rd_en.
//    The accumulator (DATA_W+4 bits) is cleared at block start and adds rd_data when valid.
//  - Result: avg2x2 = sum>>2, avg4x4 = sum>>4, truncating (no rounding).
//    Nearest modes output the single sample. The sum never overflows.
//  - WRITE: wr_en=1 for exactly 1 cycle, with wr_addr = by*(SRC_W/F)+bx and wr_data = result.
//    Blocks are traversed row-major (bx fastest), so wr_addr increments by 1 per write.
//  - Timing: first rd_en is in the cycle after start is sampled.
//    Per-block period = K + RD_LAT + 1 cycles (no overlap between blocks).
//    done is asserted in the cycle after the last wr_en.
//  - start while busy: ignored. start in the same cycle as rst: rst wins.
//    mode changes mid-frame have no effect.
// TESTING
//  1. SRC 320x240, RD_LAT=2, mode0, pixel = addr[7:0] -> 19200 writes.
//     Last wr_addr = 19199. wr_en period = 7 cycles. done 1 cycle after the last write.
//  2. mode1 on a constant-200 image -> 4800 writes, all wr_data = 200.
//     Last wr_addr = 4799. Period = 19 cycles.
//  3. Truncation: mode0, block pixels {1,2,2,2} -> wr_data = 1.
//     All-255 block in mode1 -> 255 (no overflow).
//  4. mode3 -> 1 rd_en per block; rd_addr sequence 0,4,8,...; 4800 writes.
//     wr_data equals the top-left pixel of each block.
//  5. start pulsed again mid-frame, and mode changed mid-frame -> no restart.
//     Write count and values are unchanged from test 1.
//  6. rst asserted after 100 writes -> next cycle busy=0, wr_en=0, rd_en=0, no done.
//     A new start then restarts at wr_addr 0.

Source files
------------

// File: rtl/block_downscale_engine_if.sv
// Handshake and RAM-port bundle for the block downscaler.
// The engine uses the master view; the host/RAM side uses the slave view.
interface block_downscale_engine_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  start, mode, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, mode, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/block_downscale_engine.sv
// Frame downscaler: walks the source frame in FxF blocks, reads K pixels per block
// from a fixed-latency RAM and writes one averaged or nearest pixel per block.
module block_downscale_engine #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  block_downscale_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  localparam int ACC_W = DATA_W + 4;
  // Address jumps: end of a block row to the next row, and last block of a row to the next block row.
  localparam logic [ADDR_W-1:0] DY_STEP2  = ADDR_W'(SRC_W - 1);
  localparam logic [ADDR_W-1:0] DY_STEP4  = ADDR_W'(SRC_W - 3);
  localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(SRC_W + 2);
  localparam logic [ADDR_W-1:0] ROW_STEP4 = ADDR_W'(3 * SRC_W + 4);
  localparam logic [ADDR_W-1:0] LAST_COL2 = ADDR_W'(SRC_W / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_COL4 = ADDR_W'(SRC_W / 4 - 1);
  localparam logic [ADDR_W-1:0] LAST_BLK2 = ADDR_W'((SRC_W / 2) * (SRC_H / 2) - 1);
  localparam logic [ADDR_W-1:0] LAST_BLK4 = ADDR_W'((SRC_W / 4) * (SRC_H / 4) - 1);

  state_t            state;
  logic              scale4;
  logic              nearest;
  logic [4:0]        rd_cnt;
  logic [4:0]        cap_cnt;
  logic [4:0]        k;
  logic [1:0]        dx;
  logic [1:0]        last_dx;
  logic [ADDR_W-1:0] blk_addr;
  logic [ADDR_W-1:0] next_blk;
  logic [ADDR_W-1:0] bx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [DATA_W-1:0] result;
  logic [RD_LAT-1:0] vld;
  logic              last_col;
  logic              last_blk;
  logic              last_cap;

  // NOTE: combinational logic uses blocking '=' with every output assigned; registers below use only '<='.
  always_comb begin
    k        = nearest ? 5'd1 : (scale4 ? 5'd16 : 5'd4);
    last_dx  = scale4 ? 2'd3 : 2'd1;
    last_col = (bx == (scale4 ? LAST_COL4 : LAST_COL2));
    last_blk = (wr_cnt == (scale4 ? LAST_BLK4 : LAST_BLK2));
    next_blk = blk_addr + (last_col ? (scale4 ? ROW_STEP4 : ROW_STEP2)
                                    : (scale4 ? ADDR_W'(4) : ADDR_W'(2)));
    acc_sum  = acc + ACC_W'(bus.rd_data);
    last_cap = vld[RD_LAT-1] && (cap_cnt == k - 5'd1);
    if (nearest)     result = acc_sum[DATA_W-1:0];
    else if (scale4) result = acc_sum[DATA_W+3:4];
    else             result = acc_sum[DATA_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scale4      <= 1'b0;
      nearest     <= 1'b0;
      rd_cnt      <= '0;
      cap_cnt     <= '0;
      dx          <= '0;
      blk_addr    <= '0;
      bx          <= '0;
      wr_cnt      <= '0;
      acc         <= '0;
      vld         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      // Valid tag travels alongside the read so returning data is matched without a counter per request.
      vld       <= RD_LAT'({vld, bus.rd_en});
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      if (vld[RD_LAT-1]) begin
        acc     <= acc_sum;
        cap_cnt <= cap_cnt + 5'd1;
      end

      case (state)
        IDLE: if (bus.start) begin
          scale4      <= bus.mode[0];
          nearest     <= bus.mode[1];
          bus.busy    <= 1'b1;
          bus.rd_en   <= 1'b1;
          bus.rd_addr <= '0;
          blk_addr    <= '0;
          bx          <= '0;
          wr_cnt      <= '0;
          rd_cnt      <= 5'd1;
          dx          <= '0;
          acc         <= '0;
          cap_cnt     <= '0;
          state       <= ISSUE;
        end

        ISSUE: if (rd_cnt == k) begin
          bus.rd_en <= 1'b0;
          state     <= DRAIN;
        end else begin
          rd_cnt <= rd_cnt + 5'd1;
          if (dx == last_dx) begin
            dx          <= '0;
            bus.rd_addr <= bus.rd_addr + (scale4 ? DY_STEP4 : DY_STEP2);
          end else begin
            dx          <= dx + 2'd1;
            bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
          end
        end

        DRAIN: if (last_cap) begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= wr_cnt;
          bus.wr_data <= result;
          state       <= WRITE;
        end

        WRITE: if (last_blk) begin
          bus.done <= 1'b1;
          state    <= FIN;
        end else begin
          wr_cnt      <= wr_cnt + ADDR_W'(1);
          bx          <= last_col ? '0 : bx + ADDR_W'(1);
          blk_addr    <= next_blk;
          bus.rd_addr <= next_blk;
          bus.rd_en   <= 1'b1;
          rd_cnt      <= 5'd1;
          dx          <= '0;
          acc         <= '0;
          cap_cnt     <= '0;
          state       <= ISSUE;
        end

        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_downscale_engine.sv
// Self-checking bench for block_downscale_engine: randomized frames against an
// arithmetic reference of block averages / top-left samples and address order.
module tb_block_downscale_engine;
  localparam int SRC_W  = 64;
  localparam int SRC_H  = 32;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;
  localparam int NPIX   = SRC_W * SRC_H;
  localparam int NBLK2  = (SRC_W / 2) * (SRC_H / 2);
  localparam int NBLK4  = (SRC_W / 4) * (SRC_H / 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_downscale_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  block_downscale_engine #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] img [NPIX];
  logic [7:0] pipe [RD_LAT];

  // Source RAM: data appears RD_LAT cycles after the read strobe.
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? img[int'(bus.rd_addr)] : 8'h00;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(int'(bus.wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (bus.rd_en === 1'b1) begin
      rd_addr_q.push_back(int'(bus.rd_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic int scale_of(input int mode);
    return ((mode & 1) != 0) ? 4 : 2;
  endfunction

  function automatic int exp_pix(input int mode, input int idx);
    int f, cols, bx, by, sum;
    f = scale_of(mode);
    cols = SRC_W / f;
    bx = idx % cols;
    by = idx / cols;
    if ((mode & 2) != 0) return int'(img[by * f * SRC_W + bx * f]);
    sum = 0;
    for (int dy = 0; dy < f; dy++)
      for (int dx = 0; dx < f; dx++)
        sum += int'(img[(by * f + dy) * SRC_W + bx * f + dx]);
    return sum / (f * f);
  endfunction

  // Counts writes whose address or value departs from the model; also reports the first.
  function automatic int frame_errors(input int mode, output int first);
    int bad, n;
    bad = 0;
    first = -1;
    n = (scale_of(mode) == 4) ? NBLK4 : NBLK2;
    if (wr_data_q.size() < n) n = wr_data_q.size();
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q[i] != i || wr_data_q[i] != exp_pix(mode, i)) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int rd_errors(input int mode);
    int f, k, cols, nblk, bad, b, j, expa;
    f = scale_of(mode);
    k = ((mode & 2) != 0) ? 1 : f * f;
    cols = SRC_W / f;
    nblk = (SRC_W / f) * (SRC_H / f);
    bad = (rd_addr_q.size() == nblk * k) ? 0 : 1;
    for (int i = 0; i < rd_addr_q.size() && i < nblk * k; i++) begin
      b = i / k;
      j = i % k;
      expa = ((b / cols) * f + j / f) * SRC_W + (b % cols) * f + j % f;
      if (rd_addr_q[i] != expa) bad++;
    end
    return bad;
  endfunction

  function automatic int period_errors(input int period);
    int bad;
    bad = 0;
    for (int i = 1; i < wr_cyc_q.size(); i++)
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != period) bad++;
    return bad;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic pulse_start(input logic [1:0] m, output int sc);
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    sc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cyc_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.mode = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got rd_en=%b wr_en=%b want 0 0", bus.rd_en, bus.wr_en); end
    checks++; if (bus.rd_addr !== '0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      errors++; $display("FAIL reset_buses got rd_addr=%0d wr_addr=%0d wr_data=%0d want 0 0 0",
                         bus.rd_addr, bus.wr_addr, bus.wr_data); end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++; $display("FAIL start_under_rst got busy=%b rd_en=%b want 0 0", bus.busy, bus.rd_en); end
  endtask

  task automatic test_avg2x2();
    int sc, bad, first;
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
    clear_log();
    pulse_start(2'd0, sc);
    wait_done(NBLK2 * 8 + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL avg2_done_timeout got 0 want 1"); end
    checks++; if (wr_addr_q.size() != NBLK2) begin errors++; $display("FAIL avg2_count got %0d want %0d", wr_addr_q.size(), NBLK2); end
    checks++; if (last_of(wr_addr_q) != NBLK2 - 1) begin errors++; $display("FAIL avg2_last_addr got %0d want %0d", last_of(wr_addr_q), NBLK2 - 1); end
    bad = frame_errors(0, first);
    checks++; if (bad != 0) begin errors++; $display("FAIL avg2_data got %0d bad writes (first %0d) want 0", bad, first); end
    bad = rd_errors(0);
    checks++; if (bad != 0) begin errors++; $display("FAIL avg2_rd_addr got %0d bad reads want 0", bad); end
    bad = period_errors(4 + RD_LAT + 1);
    checks++; if (bad != 0) begin errors++; $display("FAIL avg2_period got %0d bad gaps want 0", bad); end
    checks++; if ((rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1) != sc + 1) begin
      errors++; $display("FAIL avg2_first_rd got %0d want %0d", rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1, sc + 1); end
    checks++; if ((done_cyc_q.size() > 0 ? done_cyc_q[0] : -1) != last_of(wr_cyc_q) + 1) begin
      errors++; $display("FAIL avg2_done_cycle got %0d want %0d", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, last_of(wr_cyc_q) + 1); end
    repeat (3) @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL avg2_idle got busy=%b dones=%0d want 0 1", bus.busy, done_cyc_q.size()); end
  endtask

  task automatic test_avg4x4_const();
    int sc, bad;
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = 8'd200;
    clear_log();
    pulse_start(2'd1, sc);
    wait_done(NBLK4 * 20 + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL avg4_done_timeout got 0 want 1"); end
    checks++; if (wr_addr_q.size() != NBLK4) begin errors++; $display("FAIL avg4_count got %0d want %0d", wr_addr_q.size(), NBLK4); end
    checks++; if (last_of(wr_addr_q) != NBLK4 - 1) begin errors++; $display("FAIL avg4_last_addr got %0d want %0d", last_of(wr_addr_q), NBLK4 - 1); end
    bad = 0;
    foreach (wr_data_q[i]) if (wr_data_q[i] != 200) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL avg4_const got %0d writes not 200 want 0", bad); end
    bad = period_errors(16 + RD_LAT + 1);
    checks++; if (bad != 0) begin errors++; $display("FAIL avg4_period got %0d bad gaps want 0", bad); end
    bad = rd_errors(1);
    checks++; if (bad != 0) begin errors++; $display("FAIL avg4_rd_addr got %0d bad reads want 0", bad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_truncation();
    int sc, bad, first;
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    img[0] = 8'd1; img[1] = 8'd2; img[SRC_W] = 8'd2; img[SRC_W + 1] = 8'd2;
    clear_log();
    pulse_start(2'd0, sc);
    wait_done(NBLK2 * 8 + 50, ok);
    checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : -1) != 1) begin
      errors++; $display("FAIL trunc_1222 got %0d want 1", wr_data_q.size() > 0 ? wr_data_q[0] : -1); end
    bad = frame_errors(0, first);
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL trunc_random got %0d bad writes (done %0d) want 0", bad, ok); end
    repeat (3) @(negedge clk);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) img[dy * SRC_W + dx] = 8'd255;
    clear_log();
    pulse_start(2'd1, sc);
    wait_done(NBLK4 * 20 + 50, ok);
    checks++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : -1) != 255) begin
      errors++; $display("FAIL sat_255 got %0d want 255", wr_data_q.size() > 0 ? wr_data_q[0] : -1); end
    bad = frame_errors(1, first);
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL avg4_random got %0d bad writes (first %0d) want 0", bad, first); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nearest();
    int sc, bad, first;
    bit ok;
    for (int m = 2; m <= 3; m++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
      clear_log();
      pulse_start(2'(m), sc);
      wait_done(NBLK2 * 5 + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL near%0d_done_timeout got 0 want 1", m); end
      checks++; if (rd_addr_q.size() != wr_addr_q.size()) begin
        errors++; $display("FAIL near%0d_reads_per_block got %0d reads %0d writes want equal", m, rd_addr_q.size(), wr_addr_q.size()); end
      bad = rd_errors(m);
      checks++; if (bad != 0) begin errors++; $display("FAIL near%0d_rd_addr got %0d bad reads want 0", m, bad); end
      bad = frame_errors(m, first);
      checks++; if (bad != 0) begin errors++; $display("FAIL near%0d_data got %0d bad writes (first %0d) want 0", m, bad, first); end
      bad = period_errors(1 + RD_LAT + 1);
      checks++; if (bad != 0) begin errors++; $display("FAIL near%0d_period got %0d bad gaps want 0", m, bad); end
      repeat (3) @(negedge clk);
    end
    checks++; if (wr_addr_q.size() != NBLK4) begin errors++; $display("FAIL near4_count got %0d want %0d", wr_addr_q.size(), NBLK4); end
  endtask

  task automatic test_back_to_back();
    int sc, bad, first;
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
    clear_log();
    pulse_start(2'd0, sc);
    repeat (50) @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 2'd1;
    wait_done(NBLK2 * 8 + 50, ok);
    repeat (3) @(negedge clk); #1;
    checks++; if (wr_addr_q.size() != NBLK2 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL no_restart_count got %0d writes %0d dones want %0d 1", wr_addr_q.size(), done_cyc_q.size(), NBLK2); end
    bad = frame_errors(0, first);
    checks++; if (bad != 0) begin errors++; $display("FAIL no_restart_data got %0d bad writes (first %0d) want 0", bad, first); end
    bus.mode = 2'd0;
  endtask

  task automatic test_reset_mid_frame();
    int sc, bad, first, rd_seen;
    bit ok;
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    clear_log();
    pulse_start(2'd0, sc);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (wr_addr_q.size() >= 100) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_rst_reach100 got %0d writes want 100", wr_addr_q.size()); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs got busy=%b wr_en=%b rd_en=%b want 0 0 0", bus.busy, bus.wr_en, bus.rd_en); end
    rd_seen = rd_addr_q.size();
    rst = 1'b0;
    repeat (60) @(negedge clk); #1;
    checks++; if (wr_addr_q.size() != 100 || done_cyc_q.size() != 0 || rd_addr_q.size() != rd_seen) begin
      errors++; $display("FAIL mid_rst_quiet got %0d writes %0d dones %0d new reads want 100 0 0",
                         wr_addr_q.size(), done_cyc_q.size(), rd_addr_q.size() - rd_seen); end
    clear_log();
    pulse_start(2'd0, sc);
    wait_done(NBLK2 * 8 + 50, ok);
    checks++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : -1) != 0) begin
      errors++; $display("FAIL restart_first_addr got %0d want 0", wr_addr_q.size() > 0 ? wr_addr_q[0] : -1); end
    bad = frame_errors(0, first);
    checks++; if (!ok || wr_addr_q.size() != NBLK2 || bad != 0) begin
      errors++; $display("FAIL restart_frame got %0d writes %0d bad want %0d 0", wr_addr_q.size(), bad, NBLK2); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    test_reset();
    test_avg2x2();
    test_avg4x4_const();
    test_truncation();
    test_nearest();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
